acc_cpu_core: RTL and testbench

//  Parametrised multi-cycle accumulator CPU core; successor of the 4-bit-address/8-bit-data accumulator core.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/cpu_alu.sv | 65 ++++++
 rtl/acc_cpu_core.sv | 158 +++++++++++++++
 tb/tb_acc_cpu_core.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared opcodes, FSM state encoding and opcode-class helpers
//            for the accumulator CPU core.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Opcode numbering. Values above c_OP_HLT (wide opcode fields) act as NOP.
  localparam int c_OP_NOP = 0;
  localparam int c_OP_LDA = 1;
  localparam int c_OP_STA = 2;
  localparam int c_OP_ADD = 3;
  localparam int c_OP_SUB = 4;
  localparam int c_OP_AND = 5;
  localparam int c_OP_OR  = 6;
  localparam int c_OP_XOR = 7;
  localparam int c_OP_LDI = 8;
  localparam int c_OP_JMP = 9;
  localparam int c_OP_JZ  = 10;
  localparam int c_OP_JC  = 11;
  localparam int c_OP_NOT = 12;
  localparam int c_OP_SHL = 13;
  localparam int c_OP_SHR = 14;
  localparam int c_OP_HLT = 15;

  // Explicitly encoded control states.
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_MEM    = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  // Opcodes that need a data-RAM access (reads plus STA).
  function automatic logic is_mem_op(input logic [31:0] op);
    return (op >= 32'(c_OP_LDA)) && (op <= 32'(c_OP_XOR));
  endfunction

  // Memory opcodes whose RAM data feeds the accumulator.
  function automatic logic is_rd_op(input logic [31:0] op);
    return is_mem_op(op) && (op != 32'(c_OP_STA));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module   : cpu_alu
// Purpose  : Combinational ALU for the accumulator core. Produces result,
//            carry out and a carry write-enable for ops that define carry.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_alu #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4
) (
  input  logic [OPC_W-1:0]  op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cIn,
  output logic [DATA_W-1:0] y,
  output logic              cOut,
  output logic              cWe
);
  import cpu_pkg::*;

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // One extra bit holds carry-out on add and borrow (a<b) on subtract.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  // Result select; carry passes through untouched unless the op defines it.
  always_comb begin
    y    = a;
    cOut = cIn;
    cWe  = 1'b0;
    case (32'(op))
      c_OP_LDA, c_OP_LDI: y = b;
      c_OP_ADD: begin
        y    = w_sum[DATA_W-1:0];
        cOut = w_sum[DATA_W];
        cWe  = 1'b1;
      end
      c_OP_SUB: begin
        y    = w_diff[DATA_W-1:0];
        cOut = w_diff[DATA_W];
        cWe  = 1'b1;
      end
      c_OP_AND: y = a & b;
      c_OP_OR:  y = a | b;
      c_OP_XOR: y = a ^ b;
      c_OP_NOT: y = ~a;
      c_OP_SHL: begin
        y    = {a[DATA_W-2:0], 1'b0};
        cOut = a[DATA_W-1];
        cWe  = 1'b1;
      end
      c_OP_SHR: begin
        y    = {1'b0, a[DATA_W-1:1]};
        cOut = a[0];
        cWe  = 1'b1;
      end
      default: y = a;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/acc_cpu_core.sv
`default_nettype none
// ============================================================================
// Module   : acc_cpu_core
// Purpose  : Multi-cycle accumulator CPU. Fetches from an async-read ROM,
//            accesses a data RAM with a ready handshake, keeps Z/C flags,
//            supports conditional jumps, immediates, shifts, run gating
//            and halt.
// Revision : 1.0 - initial release
// ============================================================================
module acc_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  output logic [ADDR_W-1:0]       instMemAddrBus,
  input  logic [OPC_W+ADDR_W-1:0] instMemDataBus,
  output logic [ADDR_W-1:0]       dataMemAddrBus,
  output logic [DATA_W-1:0]       dataMemInDataBus,
  input  logic [DATA_W-1:0]       dataMemOutDataBus,
  input  logic                    mem_ready,
  output logic                    mReadFlag,
  output logic                    mWriteFlag,
  output logic [DATA_W-1:0]       accOut,
  output logic [DATA_W-1:0]       aluOut,
  output logic [OPC_W-1:0]        opcode,
  output logic                    flag_z,
  output logic                    flag_c,
  output logic                    halted
);
  import cpu_pkg::*;

  state_t                    r_state;
  state_t                    w_nextState;
  logic [ADDR_W-1:0]         r_pc;
  logic [OPC_W+ADDR_W-1:0]   r_ir;
  logic [DATA_W-1:0]         r_acc;
  logic                      r_zFlag;
  logic                      r_cFlag;

  logic [OPC_W-1:0]          w_opc;
  logic [31:0]               w_opNum;
  logic [ADDR_W-1:0]         w_operand;
  logic [DATA_W-1:0]         w_imm;
  logic [DATA_W-1:0]         w_aluB;
  logic [DATA_W-1:0]         w_aluY;
  logic                      w_aluCOut;
  logic                      w_aluCWe;
  logic                      w_regOp;
  logic                      w_accWe;
  logic                      w_jumpTaken;

  assign w_opc     = r_ir[OPC_W+ADDR_W-1:ADDR_W];
  assign w_opNum   = 32'(w_opc);
  assign w_operand = r_ir[ADDR_W-1:0];
  assign w_imm     = DATA_W'(w_operand);
  // Memory ops take the RAM word as second operand; everything else the immediate.
  assign w_aluB    = is_mem_op(w_opNum) ? dataMemOutDataBus : w_imm;

  cpu_alu #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W)
  ) u_alu (
    .op   (w_opc),
    .a    (r_acc),
    .b    (w_aluB),
    .cIn  (r_cFlag),
    .y    (w_aluY),
    .cOut (w_aluCOut),
    .cWe  (w_aluCWe)
  );

  // Accumulator-only ops that complete in DECODE.
  assign w_regOp = (w_opNum == 32'(c_OP_LDI)) || (w_opNum == 32'(c_OP_NOT)) ||
                   (w_opNum == 32'(c_OP_SHL)) || (w_opNum == 32'(c_OP_SHR));

  assign w_accWe = ((r_state == S_DECODE) && w_regOp) ||
                   ((r_state == S_MEM) && mem_ready && is_rd_op(w_opNum));

  // Flags are the registered values, i.e. as of DECODE entry.
  assign w_jumpTaken = (w_opNum == 32'(c_OP_JMP)) ||
                       ((w_opNum == 32'(c_OP_JZ)) && r_zFlag) ||
                       ((w_opNum == 32'(c_OP_JC)) && r_cFlag);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_nextState;
  end

  // Next-state logic; HALT is absorbing.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_FETCH:  if (run) w_nextState = S_DECODE;
      S_DECODE: begin
        if (is_mem_op(w_opNum))                w_nextState = S_MEM;
        else if (w_opNum == 32'(c_OP_HLT))     w_nextState = S_HALT;
        else                                   w_nextState = S_FETCH;
      end
      S_MEM:    if (mem_ready) w_nextState = S_FETCH;
      S_HALT:   w_nextState = S_HALT;
      default:  w_nextState = S_FETCH;
    endcase
  end

  // Memory strobes decoded purely from state so reset drops them at once.
  always_comb begin
    mReadFlag        = 1'b0;
    mWriteFlag       = 1'b0;
    dataMemAddrBus   = '0;
    dataMemInDataBus = '0;
    halted           = 1'b0;
    case (r_state)
      S_MEM: begin
        mReadFlag      = is_rd_op(w_opNum);
        mWriteFlag     = (w_opNum == 32'(c_OP_STA));
        dataMemAddrBus = w_operand;
        if (w_opNum == 32'(c_OP_STA)) dataMemInDataBus = r_acc;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Datapath: IR/pc on fetch, jump target overrides pc+1, acc and flags on write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc    <= '0;
      r_ir    <= '0;
      r_acc   <= '0;
      r_zFlag <= 1'b0;
      r_cFlag <= 1'b0;
    end else begin
      if ((r_state == S_FETCH) && run) begin
        r_ir <= instMemDataBus;
        r_pc <= r_pc + 1'b1;
      end
      if ((r_state == S_DECODE) && w_jumpTaken) r_pc <= w_operand;
      if (w_accWe) begin
        r_acc   <= w_aluY;
        r_zFlag <= (w_aluY == '0);
        if (w_aluCWe) r_cFlag <= w_aluCOut;
      end
    end
  end

  assign instMemAddrBus = r_pc;
  assign accOut         = r_acc;
  assign aluOut         = w_aluY;
  assign opcode         = w_opc;
  assign flag_z         = r_zFlag;
  assign flag_c         = r_cFlag;

endmodule
`default_nettype wire

// File: tb/tb_acc_cpu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_cpu_core
// Purpose  : Self-checking bench for acc_cpu_core with an instruction-level
//            reference model, ROM/RAM models and a wait-state RAM responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_cpu_core;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int OPC_W  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run   = 1'b0;
  logic [3:0]  instMemAddrBus;
  logic [7:0]  instMemDataBus;
  logic [3:0]  dataMemAddrBus;
  logic [7:0]  dataMemInDataBus;
  logic [7:0]  dataMemOutDataBus;
  logic        mem_ready = 1'b0;
  logic        mReadFlag, mWriteFlag;
  logic [7:0]  accOut, aluOut;
  logic [3:0]  opcode;
  logic        flag_z, flag_c, halted;

  logic [7:0]  rom [16];
  logic [7:0]  ram [16];
  int          waitCfg = 0;
  int          waitCnt = 0;
  int          checks  = 0;
  int          errors  = 0;

  // Reference model state (instruction level).
  int          mPc, mAcc;
  bit          mZ, mC, mHalt;
  int          mram [16];

  acc_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) dut (
    .clock(clock), .reset(reset), .run(run),
    .instMemAddrBus(instMemAddrBus), .instMemDataBus(instMemDataBus),
    .dataMemAddrBus(dataMemAddrBus), .dataMemInDataBus(dataMemInDataBus),
    .dataMemOutDataBus(dataMemOutDataBus), .mem_ready(mem_ready),
    .mReadFlag(mReadFlag), .mWriteFlag(mWriteFlag),
    .accOut(accOut), .aluOut(aluOut), .opcode(opcode),
    .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
  );

  always #5 clock = ~clock;

  assign instMemDataBus    = rom[instMemAddrBus];
  assign dataMemOutDataBus = ram[dataMemAddrBus];

  // RAM responder: raise ready after waitCfg idle negedges of a strobe.
  always @(negedge clock) begin
    if (mReadFlag || mWriteFlag) begin
      if (waitCnt >= waitCfg) begin
        mem_ready = 1'b1;
        if (mWriteFlag) ram[dataMemAddrBus] = dataMemInDataBus;
      end else begin
        mem_ready = 1'b0;
      end
      waitCnt++;
    end else begin
      mem_ready = 1'b0;
      waitCnt   = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'h00;
      ram[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic void model_reset();
    mPc = 0; mAcc = 0; mZ = 1'b0; mC = 1'b0; mHalt = 1'b0;
    for (int i = 0; i < 16; i++) mram[i] = int'(ram[i]);
  endfunction

  // Executes one instruction; returns the cycles it should take.
  function automatic int model_step();
    int op, opd, m, cyc;
    if (mHalt) return 1;
    op  = int'(rom[mPc]) / 16;
    opd = int'(rom[mPc]) % 16;
    mPc = (mPc + 1) % 16;
    cyc = 2;
    m   = 0;
    if (op >= 1 && op <= 7) begin
      cyc = 3 + waitCfg;
      m   = mram[opd];
    end
    case (op)
      1:  mAcc = m;
      2:  mram[opd] = mAcc;
      3:  begin mC = (mAcc + m > 255); mAcc = (mAcc + m) % 256; end
      4:  begin mC = (mAcc < m); mAcc = (mAcc - m + 256) % 256; end
      5:  mAcc = mAcc & m;
      6:  mAcc = mAcc | m;
      7:  mAcc = mAcc ^ m;
      8:  mAcc = opd;
      9:  mPc = opd;
      10: if (mZ) mPc = opd;
      11: if (mC) mPc = opd;
      12: mAcc = 255 - mAcc;
      13: begin mC = (mAcc >= 128); mAcc = (mAcc * 2) % 256; end
      14: begin mC = (mAcc % 2 == 1); mAcc = mAcc / 2; end
      15: mHalt = 1'b1;
      default: ;
    endcase
    if (op == 1 || (op >= 3 && op <= 8) || (op >= 12 && op <= 14)) mZ = (mAcc == 0);
    return cyc;
  endfunction

  task automatic test_reset();
    clear_mem();
    rom[0] = 8'h85;
    run = 1'b1;
    reset = 1'b0;
    #1;
    checks++;
    if (instMemAddrBus !== 4'h0 || accOut !== 8'h00 || opcode !== 4'h0) begin
      errors++;
      $display("FAIL reset_regs: pc=%h acc=%h opc=%h expected 0 0 0", instMemAddrBus, accOut, opcode);
    end
    checks++;
    if (flag_z !== 1'b0 || flag_c !== 1'b0 || halted !== 1'b0 || mReadFlag !== 1'b0 || mWriteFlag !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: z=%b c=%b h=%b rd=%b wr=%b expected all 0", flag_z, flag_c, halted, mReadFlag, mWriteFlag);
    end
    @(negedge clock);
    reset = 1'b1;
    tick(2);
    checks++;
    if (accOut !== 8'h05 || instMemAddrBus !== 4'h1) begin
      errors++;
      $display("FAIL reset_first_ldi: acc=%h pc=%h expected 05 1", accOut, instMemAddrBus);
    end
  endtask

  task automatic test_reset_mid_mem();
    clear_mem();
    rom[0] = 8'h87;  // LDI 7
    rom[1] = 8'h13;  // LDA 3
    waitCfg = 1000;
    do_reset();
    tick(2);
    tick(2);
    checks++;
    if (mReadFlag !== 1'b1 || dataMemAddrBus !== 4'h3 || accOut !== 8'h07) begin
      errors++;
      $display("FAIL midmem_setup: rd=%b addr=%h acc=%h expected 1 3 07", mReadFlag, dataMemAddrBus, accOut);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (mReadFlag !== 1'b0 || mWriteFlag !== 1'b0 || instMemAddrBus !== 4'h0 || accOut !== 8'h00 || dataMemAddrBus !== 4'h0) begin
      errors++;
      $display("FAIL midmem_async: rd=%b wr=%b pc=%h acc=%h addr=%h expected 0 0 0 00 0",
               mReadFlag, mWriteFlag, instMemAddrBus, accOut, dataMemAddrBus);
    end
    @(negedge clock);
    reset = 1'b1;
    tick(1);
    checks++;
    if (instMemAddrBus !== 4'h1 || opcode !== 4'h8 || accOut !== 8'h00) begin
      errors++;
      $display("FAIL midmem_refetch: pc=%h opc=%h acc=%h expected 1 8 00", instMemAddrBus, opcode, accOut);
    end
  endtask

  task automatic test_add_carry();
    clear_mem();
    rom[0] = 8'h85;  // LDI 5
    rom[1] = 8'h33;  // ADD 3
    ram[3] = 8'hFC;
    waitCfg = 2;
    do_reset();
    tick(2);
    checks++;
    if (accOut !== 8'h05) begin
      errors++;
      $display("FAIL add_ldi: acc=%h expected 05", accOut);
    end
    tick(2);
    checks++;
    if (aluOut !== 8'h01 || mReadFlag !== 1'b1) begin
      errors++;
      $display("FAIL add_aluout: alu=%h rd=%b expected 01 1", aluOut, mReadFlag);
    end
    tick(2);
    checks++;
    if (accOut !== 8'h05) begin
      errors++;
      $display("FAIL add_latency_early: acc=%h expected 05 after 4 cycles", accOut);
    end
    tick(1);
    checks++;
    if (accOut !== 8'h01 || flag_c !== 1'b1 || flag_z !== 1'b0 || instMemAddrBus !== 4'h2) begin
      errors++;
      $display("FAIL add_result: acc=%h c=%b z=%b pc=%h expected 01 1 0 2", accOut, flag_c, flag_z, instMemAddrBus);
    end
  endtask

  task automatic test_jz();
    clear_mem();
    rom[0]  = 8'h80;  // LDI 0
    rom[1]  = 8'hAA;  // JZ A
    rom[10] = 8'h81;  // LDI 1
    rom[11] = 8'hAA;  // JZ A
    waitCfg = 0;
    do_reset();
    tick(4);
    checks++;
    if (instMemAddrBus !== 4'hA || flag_z !== 1'b1) begin
      errors++;
      $display("FAIL jz_taken: pc=%h z=%b expected A 1", instMemAddrBus, flag_z);
    end
    tick(4);
    checks++;
    if (instMemAddrBus !== 4'hC || accOut !== 8'h01 || flag_z !== 1'b0) begin
      errors++;
      $display("FAIL jz_not_taken: pc=%h acc=%h z=%b expected C 01 0", instMemAddrBus, accOut, flag_z);
    end
  endtask

  task automatic test_sta();
    clear_mem();
    rom[0] = 8'h11;  // LDA 1
    rom[1] = 8'h27;  // STA 7
    ram[1] = 8'h5A;
    waitCfg = 3;
    do_reset();
    tick(6);
    tick(2);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mWriteFlag !== 1'b1 || mReadFlag !== 1'b0 || dataMemAddrBus !== 4'h7 || dataMemInDataBus !== 8'h5A) begin
        errors++;
        $display("FAIL sta_strobe%0d: wr=%b rd=%b addr=%h data=%h expected 1 0 7 5A",
                 k, mWriteFlag, mReadFlag, dataMemAddrBus, dataMemInDataBus);
      end
      tick(1);
    end
    checks++;
    if (mWriteFlag !== 1'b0 || ram[7] !== 8'h5A || instMemAddrBus !== 4'h2) begin
      errors++;
      $display("FAIL sta_done: wr=%b ram7=%h pc=%h expected 0 5A 2", mWriteFlag, ram[7], instMemAddrBus);
    end
  endtask

  task automatic test_wrap_run();
    clear_mem();
    rom[0]  = 8'h9F;  // JMP F
    rom[15] = 8'h83;  // LDI 3
    waitCfg = 0;
    do_reset();
    tick(2);
    checks++;
    if (instMemAddrBus !== 4'hF) begin
      errors++;
      $display("FAIL wrap_jmp: pc=%h expected F", instMemAddrBus);
    end
    tick(2);
    checks++;
    if (instMemAddrBus !== 4'h0 || accOut !== 8'h03) begin
      errors++;
      $display("FAIL wrap_pc: pc=%h acc=%h expected 0 03", instMemAddrBus, accOut);
    end
    run = 1'b0;
    tick(5);
    checks++;
    if (instMemAddrBus !== 4'h0 || opcode !== 4'h8) begin
      errors++;
      $display("FAIL run_hold: pc=%h opc=%h expected 0 8", instMemAddrBus, opcode);
    end
    run = 1'b1;
    tick(1);
    checks++;
    if (instMemAddrBus !== 4'h1 || opcode !== 4'h9) begin
      errors++;
      $display("FAIL run_resume: pc=%h opc=%h expected 1 9", instMemAddrBus, opcode);
    end
  endtask

  task automatic test_shr_halt();
    clear_mem();
    rom[0] = 8'h81;  // LDI 1
    rom[1] = 8'hE0;  // SHR
    rom[2] = 8'hF0;  // HLT
    rom[3] = 8'h85;  // LDI 5
    waitCfg = 0;
    do_reset();
    tick(4);
    checks++;
    if (accOut !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b1) begin
      errors++;
      $display("FAIL shr: acc=%h z=%b c=%b expected 00 1 1", accOut, flag_z, flag_c);
    end
    tick(2);
    checks++;
    if (halted !== 1'b1 || instMemAddrBus !== 4'h3) begin
      errors++;
      $display("FAIL halt_enter: h=%b pc=%h expected 1 3", halted, instMemAddrBus);
    end
    tick(10);
    checks++;
    if (halted !== 1'b1 || instMemAddrBus !== 4'h3 || accOut !== 8'h00 || opcode !== 4'hF) begin
      errors++;
      $display("FAIL halt_stay: h=%b pc=%h acc=%h opc=%h expected 1 3 00 F", halted, instMemAddrBus, accOut, opcode);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) begin
        int op;
        op = int'($urandom_range(0, 15));
        if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
        rom[i] = 8'(op * 16 + int'($urandom_range(0, 15)));
        ram[i] = 8'($urandom_range(0, 255));
      end
      waitCfg = int'($urandom_range(0, 3));
      do_reset();
      model_reset();
      for (int s = 0; s < 24; s++) begin
        int cyc;
        cyc = model_step();
        tick(cyc);
        checks++;
        if (instMemAddrBus !== 4'(mPc) || accOut !== 8'(mAcc) || flag_z !== mZ ||
            flag_c !== mC || halted !== mHalt) begin
          errors++;
          $display("FAIL random_r%0d_s%0d: pc=%h acc=%h z=%b c=%b h=%b expected pc=%h acc=%h z=%b c=%b h=%b",
                   r, s, instMemAddrBus, accOut, flag_z, flag_c, halted, 4'(mPc), 8'(mAcc), mZ, mC, mHalt);
        end
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (ram[i] !== 8'(mram[i])) begin
          errors++;
          $display("FAIL random_r%0d_ram%0d: got %h expected %h", r, i, ram[i], 8'(mram[i]));
        end
      end
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_reset_mid_mem();
    test_add_carry();
    test_jz();
    test_sta();
    test_wrap_run();
    test_shr_halt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
